surfturf_cmd_queue: RTL

SURFTURF_CMD_QUEUE -- requirements
Module: surfturf_cmd_queue

---
 rtl/surfturf_cmd_pkg.sv | 50 +++++
 rtl/surfturf_cmd_fifo.sv | 54 +++++
 rtl/surfturf_cmd_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/surfturf_cmd_pkg.sv
// Shared register map, bit positions and address decode for the command queue.
package surfturf_cmd_pkg;

  localparam int unsigned ADR_W = 6;

  localparam logic [ADR_W-1:0] ADR_CTRL      = 6'h00;
  localparam logic [ADR_W-1:0] ADR_STATUS    = 6'h04;
  localparam logic [ADR_W-1:0] ADR_PUSH_BASE = 6'h10;

  localparam int unsigned CTRL_FLUSH_BIT = 0;
  localparam int unsigned CTRL_EN_LSB    = 8;
  localparam int unsigned ST_EMPTY_LSB   = 0;
  localparam int unsigned ST_FULL_LSB    = 8;
  localparam int unsigned ST_OVF_LSB     = 16;

  localparam int unsigned SEL_FLUSH   = 0;
  localparam int unsigned SEL_PUSH    = 0;
  localparam int unsigned SEL_EN      = 1;
  localparam int unsigned SEL_OVF_CLR = 2;

  typedef enum logic [1:0] {
    REG_CTRL,
    REG_STATUS,
    REG_PUSH,
    REG_NONE
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [3:0] ch;
  } reg_dec_t;

  // Word-aligned decode; push slots exist only for implemented channels.
  function automatic reg_dec_t decode(input logic [ADR_W-1:0] adr, input int unsigned num_ch);
    reg_dec_t d;
    logic [3:0] idx;
    idx   = adr[5:2] - 4'd4;
    d.ch  = idx;
    d.sel = REG_NONE;
    if (adr == ADR_CTRL) begin
      d.sel = REG_CTRL;
    end else if (adr == ADR_STATUS) begin
      d.sel = REG_STATUS;
    end else if (adr[1:0] == 2'b00 && adr[5:2] >= ADR_PUSH_BASE[5:2] && 32'(idx) < num_ch) begin
      d.sel = REG_PUSH;
    end
    return d;
  endfunction

endpackage

// File: rtl/surfturf_cmd_fifo.sv
// First-word-fall-through FIFO; a pop frees a slot for a same-cycle push when full.
module surfturf_cmd_fifo #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 clr,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 empty,
  output logic                 full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/surfturf_cmd_queue.sv
// WISHBONE-programmed bank of per-channel command FIFOs drained over AXI4-Stream.
module surfturf_cmd_queue
  import surfturf_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [9:0]                  wb_adr_i,
  input  logic [31:0]                 wb_dat_i,
  input  logic [3:0]                  wb_sel_i,
  output logic [31:0]                 wb_dat_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic                        wb_rty_o,
  output logic [NUM_CH*DATA_BITS-1:0] cmd_tdata,
  output logic [NUM_CH-1:0]           cmd_tvalid,
  input  logic [NUM_CH-1:0]           cmd_tready
);

  logic                 ack_q;
  logic [31:0]          dat_q;
  logic [NUM_CH-1:0]    en_q;
  logic [NUM_CH-1:0]    ovf_q;
  logic [NUM_CH-1:0]    fifo_empty;
  logic [NUM_CH-1:0]    fifo_full;
  logic [DATA_BITS-1:0] fifo_dout [NUM_CH];
  logic [NUM_CH-1:0]    push;
  logic [NUM_CH-1:0]    pop;
  logic [NUM_CH-1:0]    valid;
  logic [NUM_CH-1:0]    ovf_set;
  logic [NUM_CH-1:0]    ovf_clr;
  logic [31:0]          rd_data;
  logic                 req;
  logic                 wr;
  logic                 flush;
  reg_dec_t             dec;
  logic                 unused_bits;

  assign unused_bits = ^{wb_adr_i[9:6], wb_dat_i, wb_sel_i[3]};

  assign dec   = decode(wb_adr_i[5:0], NUM_CH);
  assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr    = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
  assign flush = wr && (dec.sel == REG_CTRL) && wb_sel_i[SEL_FLUSH] && wb_dat_i[CTRL_FLUSH_BIT];

  assign valid   = ~fifo_empty & en_q;
  assign pop     = valid & cmd_tready;
  assign ovf_set = push & fifo_full & ~pop & {NUM_CH{~flush}};
  assign ovf_clr = (wr && dec.sel == REG_STATUS && wb_sel_i[SEL_OVF_CLR]) ?
                   wb_dat_i[ST_OVF_LSB +: NUM_CH] : '0;

  // Push strobe for the addressed channel, only on the ack cycle.
  always_comb begin
    push = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      push[k] = wr && (dec.sel == REG_PUSH) && wb_sel_i[SEL_PUSH] && (dec.ch == 4'(k));
    end
  end

  always_comb begin
    rd_data = '0;
    case (dec.sel)
      REG_CTRL:   rd_data[CTRL_EN_LSB +: NUM_CH] = en_q;
      REG_STATUS: begin
        rd_data[ST_EMPTY_LSB +: NUM_CH] = fifo_empty;
        rd_data[ST_FULL_LSB  +: NUM_CH] = fifo_full;
        rd_data[ST_OVF_LSB   +: NUM_CH] = ovf_q;
      end
      default: ;
    endcase
  end

  // Read data is captured with the request so it is stable across the ack cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      en_q  <= '1;
      ovf_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wb_we_i) ? rd_data : '0;
      if (wr && dec.sel == REG_CTRL && wb_sel_i[SEL_EN]) begin
        en_q <= wb_dat_i[CTRL_EN_LSB +: NUM_CH];
      end
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    surfturf_cmd_fifo #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .clr       (flush),
      .push      (push[k]),
      .pop       (pop[k]),
      .din       (wb_dat_i[DATA_BITS-1:0]),
      .dout      (fifo_dout[k]),
      .empty     (fifo_empty[k]),
      .full      (fifo_full[k])
    );
    assign cmd_tdata[k*DATA_BITS +: DATA_BITS] = valid[k] ? fifo_dout[k] : '0;
  end

  assign cmd_tvalid = valid;
  assign wb_ack_o   = ack_q & wb_cyc_i;
  assign wb_dat_o   = dat_q;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;

endmodule
